// File: rtl/ebpf_wb_pkg.sv
// Shared types and constants for the eBPF writeback unit and its ALU result FIFO.
package ebpf_wb_pkg;

  localparam int NUM_GPRS = 10;

  typedef logic [3:0] reg_idx_t;

  // INVALID_DST matches the register file's own exception code.
  typedef enum logic [1:0] {
    NO_EXCEPTION    = 2'd0,
    INVALID_DST     = 2'd1,
    UNEXPECTED_LOAD = 2'd2
  } wb_exc_t;

  typedef struct packed {
    reg_idx_t    dst;
    logic [63:0] data;
  } wb_item_t;

endpackage

// File: rtl/ebpf_writeback_unit_fifo.sv
// Circular buffer for ALU results waiting on the register-file write port.
// Exposes per-slot valid/dst so the hazard logic can see buffered destinations.
module wb_alu_fifo
  import ebpf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_item_t                   push_item,
  input  logic                       pop,
  output wb_item_t                   head,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           entry_valid,
  output reg_idx_t [DEPTH-1:0]       entry_dst
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_item_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] slot_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      if (pop) begin
        rd_ptr             <= rd_ptr + PTR_W'(1);
        slot_valid[rd_ptr] <= 1'b0;
      end
      // Push after pop so a full-buffer push/pop on the same slot keeps it valid.
      if (push) begin
        mem[wr_ptr]        <= push_item;
        wr_ptr             <= wr_ptr + PTR_W'(1);
        slot_valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign entry_valid = slot_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_dst[i] = mem[i].dst;
    end
  end

endmodule

// File: rtl/ebpf_writeback_unit.sv
// Register-file write master: merges ALU and load results, tracks pending loads, flags hazards.
// Optional WB_FORWARD_EN adds a forwarding path from the output stage to the issuing source.
module ebpf_writeback_unit
  import ebpf_wb_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int NUM_GPRS       = ebpf_wb_pkg::NUM_GPRS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  reg_idx_t    alu_dst,
  input  logic [63:0] alu_data,
  input  logic        ld_issue,
  input  reg_idx_t    ld_issue_dst,
  input  logic        ld_valid,
  input  reg_idx_t    ld_dst,
  input  logic [63:0] ld_data,
  input  reg_idx_t    chk_src,
  input  logic        chk_src_used,
  input  reg_idx_t    chk_dst,
  output logic        hazard,
  output reg_idx_t    rf_dst,
  output logic [63:0] rf_write_data,
  output logic        rf_write_en,
  output wb_exc_t     wb_exc
`ifdef WB_FORWARD_EN
  ,
  output logic        fwd_valid,
  output logic [63:0] fwd_data
`endif
);

  localparam int CNT_W = $clog2(ALU_FIFO_DEPTH) + 1;

  logic [NUM_GPRS-1:0]            pending;
  logic [NUM_GPRS-1:0]            pending_next;
  logic                           ld_was_pending;
  wb_exc_t                        exc_next;
  logic [CNT_W-1:0]               fifo_count;
  logic [ALU_FIFO_DEPTH-1:0]      fifo_valid;
  reg_idx_t [ALU_FIFO_DEPTH-1:0]  fifo_dst;
  wb_item_t                       fifo_head;
  wb_item_t                       sel_item;
  logic                           sel_any;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           alu_accept;
  logic [15:0]                    busy_core;
  logic [15:0]                    out_hit;
  logic                           src_busy;

  function automatic logic idx_ok(reg_idx_t idx);
    return int'(idx) < NUM_GPRS;
  endfunction

  wb_alu_fifo #(.DEPTH(ALU_FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_item   ('{dst: alu_dst, data: alu_data}),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .count       (fifo_count),
    .entry_valid (fifo_valid),
    .entry_dst   (fifo_dst)
  );

  assign alu_ready  = fifo_count < CNT_W'(ALU_FIFO_DEPTH);
  assign alu_accept = alu_valid & alu_ready;

  // Load data first, then the oldest buffered ALU result, then an ALU bypass.
  always_comb begin
    sel_any   = 1'b1;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    sel_item  = '{dst: alu_dst, data: alu_data};
    if (ld_valid) begin
      sel_item  = '{dst: ld_dst, data: ld_data};
      fifo_push = alu_accept;
    end else if (fifo_count != '0) begin
      sel_item  = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = alu_accept;
    end else begin
      sel_any = alu_accept;
    end
  end

  always_comb begin
    pending_next   = pending;
    ld_was_pending = 1'b0;
    for (int i = 0; i < NUM_GPRS; i++) begin
      if (ld_dst == reg_idx_t'(i)) ld_was_pending = pending[i];
      if (ld_valid && ld_dst == reg_idx_t'(i)) pending_next[i] = 1'b0;
      if (ld_issue && ld_issue_dst == reg_idx_t'(i)) pending_next[i] = 1'b1;
    end
    exc_next = NO_EXCEPTION;
    if ((sel_any && !idx_ok(sel_item.dst)) || (ld_issue && !idx_ok(ld_issue_dst)))
      exc_next = INVALID_DST;
    else if (ld_valid && idx_ok(ld_dst) && !ld_was_pending)
      exc_next = UNEXPECTED_LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      rf_write_en   <= 1'b0;
      rf_dst        <= '0;
      rf_write_data <= '0;
      wb_exc        <= NO_EXCEPTION;
    end else begin
      pending     <= pending_next;
      wb_exc      <= exc_next;
      rf_write_en <= sel_any && idx_ok(sel_item.dst);
      if (sel_any) begin
        rf_dst        <= sel_item.dst;
        rf_write_data <= sel_item.data;
      end
    end
  end

  // Vectors padded to the full index range so an invalid index reads as not busy.
  always_comb begin
    busy_core = '0;
    out_hit   = '0;
    for (int i = 0; i < NUM_GPRS; i++) begin
      busy_core[i] = pending[i];
      for (int e = 0; e < ALU_FIFO_DEPTH; e++) begin
        if (fifo_valid[e] && fifo_dst[e] == reg_idx_t'(i)) busy_core[i] = 1'b1;
      end
      out_hit[i] = rf_write_en && (rf_dst == reg_idx_t'(i));
    end
  end

`ifdef WB_FORWARD_EN
  assign src_busy  = busy_core[chk_src];
  assign fwd_valid = chk_src_used & out_hit[chk_src];
  assign fwd_data  = rf_write_data;
`else
  assign src_busy  = busy_core[chk_src] | out_hit[chk_src];
`endif

  assign hazard = (chk_src_used & src_busy) | busy_core[chk_dst] | out_hit[chk_dst];

endmodule

// File: tb/tb_ebpf_writeback_unit.sv
// Scoreboard bench for ebpf_writeback_unit: a queue-based reference model predicts each cycle's
// register-file write and exception; a negedge monitor pops and compares.
module tb_ebpf_writeback_unit;

  localparam int DEPTH = 2;
  localparam int NGPR  = 10;

  typedef struct {
    logic        reset;
    logic        alu_valid;
    logic [3:0]  alu_dst;
    logic [63:0] alu_data;
    logic        ld_issue;
    logic [3:0]  ld_issue_dst;
    logic        ld_valid;
    logic [3:0]  ld_dst;
    logic [63:0] ld_data;
    logic [3:0]  chk_src;
    logic        chk_src_used;
    logic [3:0]  chk_dst;
  } stim_t;

  typedef struct {
    logic [3:0]  dst;
    logic [63:0] data;
  } item_t;

  typedef struct {
    bit          en;
    bit          chk_all;
    logic [3:0]  dst;
    logic [63:0] data;
    logic [1:0]  exc;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_dst;
  logic [63:0] alu_data;
  logic        ld_issue;
  logic [3:0]  ld_issue_dst;
  logic        ld_valid;
  logic [3:0]  ld_dst;
  logic [63:0] ld_data;
  logic [3:0]  chk_src;
  logic        chk_src_used;
  logic [3:0]  chk_dst;
  logic        hazard;
  logic [3:0]  rf_dst;
  logic [63:0] rf_write_data;
  logic        rf_write_en;
  logic [1:0]  wb_exc;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [63:0] fwd_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  rec_t  expq[$];
  item_t mq[$];
  bit [15:0]   mpend;
  bit          last_en;
  logic [3:0]  last_dst;
  logic [63:0] last_data;
  bit          last_accept;

  always #5 clk = ~clk;

  ebpf_writeback_unit #(.ALU_FIFO_DEPTH(DEPTH), .NUM_GPRS(NGPR)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_dst       (alu_dst),
    .alu_data      (alu_data),
    .ld_issue      (ld_issue),
    .ld_issue_dst  (ld_issue_dst),
    .ld_valid      (ld_valid),
    .ld_dst        (ld_dst),
    .ld_data       (ld_data),
    .chk_src       (chk_src),
    .chk_src_used  (chk_src_used),
    .chk_dst       (chk_dst),
    .hazard        (hazard),
    .rf_dst        (rf_dst),
    .rf_write_data (rf_write_data),
    .rf_write_en   (rf_write_en),
    .wb_exc        (wb_exc)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid     (fwd_valid),
    .fwd_data      (fwd_data)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{reset: 1'b0, alu_valid: 1'b0, alu_dst: 4'd0, alu_data: 64'd0, ld_issue: 1'b0,
          ld_issue_dst: 4'd0, ld_valid: 1'b0, ld_dst: 4'd0, ld_data: 64'd0, chk_src: 4'd0,
          chk_src_used: 1'b0, chk_dst: 4'hF};
    return s;
  endfunction

  function automatic bit busy(logic [3:0] r, bit incl_out);
    if (int'(r) >= NGPR) return 1'b0;
    if (mpend[r]) return 1'b1;
    foreach (mq[i]) if (mq[i].dst == r) return 1'b1;
    return incl_out && last_en && (last_dst == r);
  endfunction

  function automatic void model_reset();
    mq.delete();
    mpend   = '0;
    last_en = 1'b0;
  endfunction

  task automatic applyStimulus(input stim_t s);
    bit    exp_ready, exp_haz, acc, have, inv, unexp;
    item_t alu_it, sel;
    rec_t  r;
    reset = s.reset; alu_valid = s.alu_valid; alu_dst = s.alu_dst; alu_data = s.alu_data;
    ld_issue = s.ld_issue; ld_issue_dst = s.ld_issue_dst; ld_valid = s.ld_valid;
    ld_dst = s.ld_dst; ld_data = s.ld_data; chk_src = s.chk_src;
    chk_src_used = s.chk_src_used; chk_dst = s.chk_dst;
    #1;
    exp_ready = mq.size() < DEPTH;
`ifdef WB_FORWARD_EN
    exp_haz = (s.chk_src_used && busy(s.chk_src, 1'b0)) || busy(s.chk_dst, 1'b1);
    checkOutput("fwd_valid", 64'(fwd_valid),
                64'(s.chk_src_used && last_en && last_dst == s.chk_src));
    if (s.chk_src_used && last_en && last_dst == s.chk_src)
      checkOutput("fwd_data", fwd_data, last_data);
`else
    exp_haz = (s.chk_src_used && busy(s.chk_src, 1'b1)) || busy(s.chk_dst, 1'b1);
`endif
    checkOutput("alu_ready", 64'(alu_ready), 64'(exp_ready));
    checkOutput("hazard", 64'(hazard), 64'(exp_haz));
    last_accept = 1'b0;
    if (s.reset) begin
      model_reset();
      r = '{en: 1'b0, chk_all: 1'b1, dst: 4'd0, data: 64'd0, exc: 2'd0};
    end else begin
      acc         = s.alu_valid && exp_ready;
      last_accept = acc;
      alu_it      = '{dst: s.alu_dst, data: s.alu_data};
      have        = 1'b1;
      sel         = alu_it;
      if (s.ld_valid) sel = '{dst: s.ld_dst, data: s.ld_data};
      else if (mq.size() > 0) sel = mq.pop_front();
      else if (acc) acc = 1'b0;
      else have = 1'b0;
      if (acc) mq.push_back(alu_it);
      inv   = (have && int'(sel.dst) >= NGPR) || (s.ld_issue && int'(s.ld_issue_dst) >= NGPR);
      unexp = s.ld_valid && int'(s.ld_dst) < NGPR && !mpend[s.ld_dst];
      if (s.ld_valid && int'(s.ld_dst) < NGPR) mpend[s.ld_dst] = 1'b0;
      if (s.ld_issue && int'(s.ld_issue_dst) < NGPR) mpend[s.ld_issue_dst] = 1'b1;
      r = '{en: have && int'(sel.dst) < NGPR, chk_all: 1'b0, dst: sel.dst, data: sel.data,
            exc: inv ? 2'd1 : (unexp ? 2'd2 : 2'd0)};
      last_en   = r.en;
      last_dst  = sel.dst;
      last_data = sel.data;
    end
    expq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (mon_en) begin
      if (expq.size() == 0) begin
        checkOutput("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        r = expq.pop_front();
        checkOutput("rf_write_en", 64'(rf_write_en), 64'(r.en));
        checkOutput("wb_exc", 64'(wb_exc), 64'(r.exc));
        if (r.en || r.chk_all) begin
          checkOutput("rf_dst", 64'(rf_dst), 64'(r.dst));
          checkOutput("rf_write_data", rf_write_data, r.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stim_t s;
    int    k;
    logic [3:0] ofr_dst [3];
    ofr_dst[0] = 4'd4; ofr_dst[1] = 4'd5; ofr_dst[2] = 4'd6;

    s = idle();
    s.reset = 1'b1;
    reset = 1'b1; alu_valid = 0; alu_dst = 0; alu_data = 0; ld_issue = 0; ld_issue_dst = 0;
    ld_valid = 0; ld_dst = 0; ld_data = 0; chk_src = 0; chk_src_used = 0; chk_dst = 4'hF;
    model_reset();
    @(posedge clk);
    #1;
    expq.push_back('{en: 1'b0, chk_all: 1'b1, dst: 4'd0, data: 64'd0, exc: 2'd0});
    mon_en = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle());

    // ALU bypass into an idle write port.
    s = idle(); s.alu_valid = 1; s.alu_dst = 4'd3; s.alu_data = 64'hDEAD;
    applyStimulus(s);
    applyStimulus(idle());

    // Load and ALU collide; ALU result is buffered for one cycle.
    s = idle(); s.ld_valid = 1; s.ld_dst = 4'd1; s.ld_data = 64'h11;
    s.alu_valid = 1; s.alu_dst = 4'd2; s.alu_data = 64'h22;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());

    // Three cycles of load data back-pressure the ALU stream r4, r5, r6.
    k = 0;
    for (int c = 0; c < 10 && k < 3; c++) begin
      s = idle();
      s.ld_valid = (c < 3); s.ld_dst = 4'd0; s.ld_data = 64'(c) + 64'hA0;
      s.alu_valid = 1; s.alu_dst = ofr_dst[k]; s.alu_data = 64'h400 + 64'(k);
      applyStimulus(s);
      if (last_accept) k++;
    end
    checkOutput("alu_stream_done", 64'(k), 64'd3);
    repeat (3) applyStimulus(idle());

    // Pending load on r7 blocks a reader until the data is written.
    s = idle(); s.ld_issue = 1; s.ld_issue_dst = 4'd7;
    applyStimulus(s);
    for (int c = 0; c < 7; c++) begin
      s = idle(); s.chk_src = 4'd7; s.chk_src_used = 1;
      if (c == 3) begin s.ld_valid = 1; s.ld_dst = 4'd7; s.ld_data = 64'h77; end
      applyStimulus(s);
    end

    // Invalid ALU destination, then an unexpected load.
    s = idle(); s.alu_valid = 1; s.alu_dst = 4'd12; s.alu_data = 64'hBAD;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());
    s = idle(); s.ld_valid = 1; s.ld_dst = 4'd9; s.ld_data = 64'h99;
    applyStimulus(s);
    s = idle(); s.ld_issue = 1; s.ld_issue_dst = 4'd14;
    applyStimulus(s);
    applyStimulus(idle());

    // Reset with two buffered results and r5 pending.
    s = idle(); s.ld_issue = 1; s.ld_issue_dst = 4'd5;
    applyStimulus(s);
    for (int c = 0; c < 3; c++) begin
      s = idle(); s.ld_valid = 1; s.ld_dst = 4'd0; s.ld_data = 64'hC0;
      s.alu_valid = 1; s.alu_dst = 4'(c + 1); s.alu_data = 64'hE0 + 64'(c);
      applyStimulus(s);
    end
    s = idle(); s.reset = 1; s.chk_src = 4'd5; s.chk_src_used = 1;
    applyStimulus(s);
    s = idle(); s.chk_src = 4'd5; s.chk_src_used = 1; s.chk_dst = 4'd5;
    applyStimulus(s);
    applyStimulus(s);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      s = idle();
      s.reset        = ($urandom_range(99) == 0);
      s.alu_valid    = ($urandom_range(9) < 6);
      s.alu_dst      = ($urandom_range(9) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
      s.alu_data     = {$urandom, $urandom};
      s.ld_issue     = ($urandom_range(9) < 2);
      s.ld_issue_dst = ($urandom_range(19) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
      s.ld_valid     = ($urandom_range(9) < 3);
      s.ld_dst       = ($urandom_range(19) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
      s.ld_data      = {$urandom, $urandom};
      s.chk_src      = 4'($urandom_range(11));
      s.chk_src_used = 1'($urandom_range(1));
      s.chk_dst      = 4'($urandom_range(11));
      applyStimulus(s);
    end

    repeat (6) applyStimulus(idle());
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
